axi_sram_slave: RTL
===================

AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256: number of 32-bit words of backing storage.
REQ-002 SHALL have parameter BASE_ADDR, default 32'h80000000: byte address of word 0.
REQ-003 SHALL have parameter READ_DELAY, default 2, range 1..15: cycles from AR handshake to rvalid.
REQ-004 SHALL have parameter WRITE_DELAY, default 2, range 1..15: cycles from AW/W handshake to bvalid.
REQ-005 Ports (clock and reset first); reset is asynchronous and active-high:
  clk  input  1  single clock, rising edge
  rst  input  1  asynchronous, active-high reset
  araddr  input  32  read byte address
  arvalid  input  1  read address valid
  arready  output  1  read address ready
  rdata  output  32  read data
  rresp  output  2  read response: 0 OKAY, 2 SLVERR
  rvalid  output  1  read data valid
  rready  input  1  read data ready
  awaddr  input  32  write byte address
  awvalid  input  1  write address valid
  awready  output  1  write address ready
  wdata  input  32  write data
  wstrb  input  8  byte strobes; [3:0] used, [7:4] ignored
  wvalid  input  1  write data valid
  wready  output  1  write data ready
  bresp  output  2  write response: 0 OKAY, 2 SLVERR
  bvalid  output  1  write response valid
  bready  input  1  write response ready

Function
REQ-006 SHALL implement a state machine with states IDLE, RD_WAIT, RD_RESP, WR_WAIT and WR_RESP; all state changes occur on the rising edge of clk.
REQ-007 SHALL drive arready = (state==IDLE) and awready = wready = (state==IDLE && !arvalid); these are combinational decodes of registered state and arvalid only.
REQ-008 AR handshake: arvalid && arready in IDLE SHALL capture araddr, load the delay counter with READ_DELAY-1, and move to RD_WAIT.
REQ-009 Simultaneous arvalid and awvalid/wvalid in IDLE SHALL accept the read only; the write waits, with awready and wready held low.
REQ-010 Write accept SHALL require awvalid && wvalid in the same IDLE cycle; one without the other SHALL NOT be accepted, and the design SHALL remain in IDLE.
REQ-011 On a write accept the design SHALL capture awaddr, wdata and wstrb[3:0], load the counter with WRITE_DELAY-1, and move to WR_WAIT.
REQ-012 RD_WAIT/WR_WAIT SHALL decrement the counter each cycle; at counter==0 the design SHALL move to RD_RESP/WR_RESP, so rvalid/bvalid rise exactly READ_DELAY/WRITE_DELAY cycles after the handshake edge.
REQ-013 Word index SHALL be (addr - BASE_ADDR) >> 2, with addr[1:0] ignored; the address is in range iff BASE_ADDR <= addr < BASE_ADDR + 4*DEPTH_WORDS, using 32-bit unsigned compare with no wrap.
REQ-014 In-range read: rdata SHALL be the stored word and rresp = 0; out-of-range read: rdata = 32'h0 and rresp = 2.
REQ-015 In-range write SHALL update only the bytes whose wstrb[i] is 1, on the edge entering WR_RESP, with bresp = 0; an out-of-range write SHALL leave memory unchanged, with bresp = 2.
REQ-016 rdata/rresp SHALL be registered, loaded when entering RD_RESP, and held stable while rvalid && !rready; the same holds for bresp while bvalid && !bready.
REQ-017 RD_RESP SHALL return to IDLE on rvalid && rready, and WR_RESP SHALL return to IDLE on bvalid && bready; the next request can be accepted in the cycle after that handshake.
REQ-018 At most one transaction SHALL be outstanding; arready, awready and wready SHALL be 0 in every non-IDLE state.
REQ-019 A read issued after a write response completes SHALL observe the written data.

Reset
REQ-020 Asserting rst SHALL asynchronously force state=IDLE, counter=0, rvalid=0, bvalid=0, rdata=0, rresp=0 and bresp=0, so arready=1 is visible as soon as rst is released.
REQ-021 rst asserted mid-transaction SHALL abort that transaction with no response issued; a write that has not yet entered WR_RESP SHALL NOT modify memory.
REQ-022 Memory contents SHALL NOT be affected by reset.

Verification
REQ-023 Write 0x80000010 data 0xDEADBEEF wstrb 0xF, then read 0x80000010 -> bvalid 2 cycles after accept with bresp 0; rvalid 2 cycles after AR with rdata 0xDEADBEEF, rresp 0.
REQ-024 Write 0x80000010 data 0x11223344 wstrb 0x5 over 0xDEADBEEF, then read -> rdata 0xDE22BE44.
REQ-025 Read 0x7FFFFFFC and write 0x80000400 with default DEPTH_WORDS -> rresp 2 with rdata 0, bresp 2, and memory unchanged.
REQ-026 arvalid, awvalid and wvalid all high in IDLE -> read accepted first with awready 0; the write is accepted in the cycle after rready completes the read.
REQ-027 Hold rready=0 for 5 cycles after rvalid rises -> rvalid, rdata and rresp stay constant; state leaves RD_RESP in the cycle after rready=1.
REQ-028 Assert rst in WR_WAIT with data 0xA5A5A5A5 -> bvalid never rises, a later read of that address returns the old value, and arready=1 after reset is released.

Source files
------------

// File: rtl/axi_sram_slave.sv
// AXI-lite style single-outstanding SRAM slave with programmable read/write latency.
// One transaction is in flight at a time; reads win over writes when both are presented.
module axi_sram_slave #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned READ_DELAY  = 2,
  parameter int unsigned WRITE_DELAY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int unsigned IDX_W   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] LIMIT   = {1'b0, BASE_ADDR} + (33'(DEPTH_WORDS) * 33'd4);
  localparam logic [3:0]  RD_LOAD = 4'(READ_DELAY - 1);
  localparam logic [3:0]  WR_LOAD = 4'(WRITE_DELAY - 1);
  localparam logic [1:0]  OKAY    = 2'd0;
  localparam logic [1:0]  SLVERR  = 2'd2;

  typedef enum logic [2:0] {IDLE, RD_WAIT, RD_RESP, WR_WAIT, WR_RESP} state_t;

  state_t            r_state, w_next;
  logic [3:0]        r_cnt;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic [31:0]       r_rdata;
  logic [1:0]        r_rresp;
  logic [1:0]        r_bresp;
  logic [31:0]       r_mem [DEPTH_WORDS];

  logic              w_rd_acc;
  logic              w_wr_acc;
  logic              w_rd_done;
  logic              w_wr_done;
  logic [31:0]       w_off;
  logic [IDX_W-1:0]  w_idx;
  logic              w_in_range;

  assign arready = (r_state == IDLE);
  assign awready = (r_state == IDLE) && !arvalid;
  assign wready  = (r_state == IDLE) && !arvalid;
  assign rvalid  = (r_state == RD_RESP);
  assign bvalid  = (r_state == WR_RESP);
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;
  assign bresp   = r_bresp;

  assign w_rd_acc  = arvalid && arready;
  assign w_wr_acc  = awvalid && wvalid && awready;
  assign w_rd_done = (r_state == RD_WAIT) && (r_cnt == 4'd0);
  assign w_wr_done = (r_state == WR_WAIT) && (r_cnt == 4'd0);

  // 33-bit upper compare so a window ending at 2^32 cannot wrap.
  assign w_off      = r_addr - BASE_ADDR;
  assign w_idx      = w_off[IDX_W+1:2];
  assign w_in_range = (r_addr >= BASE_ADDR) && ({1'b0, r_addr} < LIMIT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_rd_acc)      w_next = RD_WAIT;
        else if (w_wr_acc) w_next = WR_WAIT;
      end
      RD_WAIT: if (r_cnt == 4'd0) w_next = RD_RESP;
      RD_RESP: if (rready)        w_next = IDLE;
      WR_WAIT: if (r_cnt == 4'd0) w_next = WR_RESP;
      WR_RESP: if (bready)        w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt   <= 4'd0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_wstrb <= 4'd0;
      r_rdata <= 32'd0;
      r_rresp <= OKAY;
      r_bresp <= OKAY;
    end else begin
      if (w_rd_acc) begin
        r_addr <= araddr;
        r_cnt  <= RD_LOAD;
      end else if (w_wr_acc) begin
        r_addr  <= awaddr;
        r_wdata <= wdata;
        r_wstrb <= wstrb[3:0];
        r_cnt   <= WR_LOAD;
      end else if ((r_state == RD_WAIT || r_state == WR_WAIT) && r_cnt != 4'd0) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_rd_done) begin
        r_rdata <= w_in_range ? r_mem[w_idx] : 32'd0;
        r_rresp <= w_in_range ? OKAY : SLVERR;
      end
      if (w_wr_done) r_bresp <= w_in_range ? OKAY : SLVERR;
    end
  end

  // Storage has no reset; a write aborted by rst never reaches WR_WAIT/cnt==0 here.
  always_ff @(posedge clk) begin
    if (w_wr_done && w_in_range) begin
      for (int b = 0; b < 4; b++)
        if (r_wstrb[b]) r_mem[w_idx][8*b +: 8] <= r_wdata[8*b +: 8];
    end
  end

endmodule
